// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Default values describe 640x480@60 Hz on a 25 MHz pixel clock.
// No ports; imported by vga_timing_gen_if, vga_timing_gen and the bench.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_PIPE_DLY  = 2;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Idle levels of the delayed sync bundle, ordered {hs, vs, blank}.
    localparam logic [2:0] SYNC_RST_VAL = 3'b110;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by sprite
// mappers / game logic.
//   master : driver side (timing generator), all signals outputs
//   slave  : consumer side, all signals inputs
// Signals: DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d, frame_start,
// vblank_start, and frame_count when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   hs_d;
    logic   vs_d;
    logic   blank_d;
    logic   frame_start;
    logic   vblank_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, vblank_start, frame_count
    );
    modport slave (
        input  DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, vblank_start, frame_count
    );
`else
    modport master (
        output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, vblank_start
    );
    modport slave (
        input  DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, vblank_start
    );
`endif

endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register used to align sync/blank with the registered
// colour path of the sprite mappers.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, loads every stage with RST_VAL
//   d_i    : WIDTH-bit input
//   q_o    : d_i delayed DEPTH cycles (DEPTH=0 is a combinational pass-through)
module vga_sync_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60 Hz, 25 MHz pixel clock).
// Produces pixel coordinates, active-low syncs, the visible-region flag,
// PIPE_DLY-cycle delayed copies of hs/vs/blank, and frame / vblank strobes.
//   vga_clk : pixel clock
//   reset   : asynchronous active-high reset
//   vga     : vga_timing_gen_if.master bundle (see interface for signals)
// Optional: define VGA_FRAME_COUNT_EN to add an 8-bit frame_count that
// advances with every frame_start except the first one after reset.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int PIPE_DLY  = DEF_PIPE_DLY
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t H_SS     = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SE     = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t V_SS     = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SE     = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   running_q;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   blank_q, blank_d;
    logic   fs_q, fs_d;
    logic   vb_q, vb_d;
    logic [2:0] sync_dly;

    // The first edge after reset holds the counters at the origin so that
    // the first visible cycle is pixel (0,0) with frame_start raised.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (running_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decoded from the next count so the flags land with the counters.
        hs_d    = !((x_d >= H_SS) && (x_d <= H_SE));
        vs_d    = !((y_d >= V_SS) && (y_d <= V_SE));
        blank_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        fs_d    = (x_d == '0) && (y_d == '0);
        vb_d    = (x_d == '0) && (y_d == V_VIS_C);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            running_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_q   <= 1'b0;
            fs_q      <= 1'b0;
            vb_q      <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            running_q <= 1'b1;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_q   <= blank_d;
            fs_q      <= fs_d;
            vb_q      <= vb_d;
        end
    end

    vga_sync_delay #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL (SYNC_RST_VAL)
    ) u_sync_delay (
        .clk_i (vga_clk),
        .rst_i (reset),
        .d_i   ({hs_q, vs_q, blank_q}),
        .q_o   (sync_dly)
    );

    assign vga.DrawX        = x_q;
    assign vga.DrawY        = y_q;
    assign vga.hs           = hs_q;
    assign vga.vs           = vs_q;
    assign vga.blank        = blank_q;
    assign vga.frame_start  = fs_q;
    assign vga.vblank_start = vb_q;
    assign vga.hs_d         = sync_dly[2];
    assign vga.vs_d         = sync_dly[1];
    assign vga.blank_d      = sync_dly[0];

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fcnt_q, fcnt_d;
    logic       fcnt_arm_q, fcnt_arm_d;

    // The first frame_start after reset only arms the counter, so frame 0
    // reads 0 and each later frame_start edge shows the new count.
    always_comb begin
        fcnt_d     = fcnt_q;
        fcnt_arm_d = fcnt_arm_q;
        if (fs_d) begin
            if (fcnt_arm_q) begin
                fcnt_d = fcnt_q + 8'd1;
            end
            fcnt_arm_d = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            fcnt_q     <= '0;
            fcnt_arm_q <= 1'b0;
        end else begin
            fcnt_q     <= fcnt_d;
            fcnt_arm_q <= fcnt_arm_d;
        end
    end

    assign vga.frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Reduced raster for the second instance so full frames fit in a short run.
    localparam int SH_VIS = 32, SH_FP = 4, SH_SYNC = 8, SH_BP = 4;
    localparam int SV_VIS = 24, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
    localparam int SHT = 48;
    localparam int SFT = 48 * 31;

    logic vga_clk = 1'b0;
    logic rst;
    logic rst_s;
    always #20 vga_clk = ~vga_clk;

    vga_timing_gen_if vif ();
    vga_timing_gen_if sif ();

    vga_timing_gen dut (
        .vga_clk (vga_clk),
        .reset   (rst),
        .vga     (vif.master)
    );

    vga_timing_gen #(
        .H_VISIBLE (SH_VIS), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
        .V_VISIBLE (SV_VIS), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP),
        .PIPE_DLY  (0)
    ) dut_s (
        .vga_clk (vga_clk),
        .reset   (rst_s),
        .vga     (sif.master)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle index since reset release: 0 while in reset / before first edge.
    int n_def, n_s;
    always @(posedge vga_clk or posedge rst)
        if (rst) n_def <= 0; else n_def <= n_def + 1;
    always @(posedge vga_clk or posedge rst_s)
        if (rst_s) n_s <= 0; else n_s <= n_s + 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs, vs, blank, fs, vb;
        logic [7:0] fc;
    } exp_t;

    function automatic exp_t model(input int n, input int hv, input int hfp, input int hsw,
                                   input int hbp, input int vv, input int vfp, input int vsw,
                                   input int vbp);
        exp_t e;
        int ht, vt, p, x, y;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        if (n == 0) begin
            e = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, vb: 1'b0, fc: 8'd0};
            return e;
        end
        p = n - 1;
        x = p % ht;
        y = (p / ht) % vt;
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.hs    = !(x >= hv + hfp && x <= hv + hfp + hsw - 1);
        e.vs    = !(y >= vv + vfp && y <= vv + vfp + vsw - 1);
        e.blank = (x < hv) && (y < vv);
        e.fs    = (x == 0) && (y == 0);
        e.vb    = (x == 0) && (y == vv);
        e.fc    = 8'((p / (ht * vt)) % 256);
        return e;
    endfunction

    // Per-cycle model comparison; delayed outputs checked via a scoreboard
    // queue of model values pushed each cycle and popped PIPE_DLY cycles later.
    logic [2:0] sb_def[$];
    exp_t ed, es;
    logic [2:0] popped;
    always @(negedge vga_clk) begin
        ed = model(n_def, 640, 16, 96, 48, 480, 10, 2, 33);
        check("def_DrawX", vif.DrawX, ed.x);
        check("def_DrawY", vif.DrawY, ed.y);
        check("def_hs", vif.hs, ed.hs);
        check("def_vs", vif.vs, ed.vs);
        check("def_blank", vif.blank, ed.blank);
        check("def_frame_start", vif.frame_start, ed.fs);
        check("def_vblank_start", vif.vblank_start, ed.vb);
        if (n_def == 0) begin
            sb_def = '{3'b110, 3'b110};
            popped = 3'b110;
        end else begin
            sb_def.push_back({ed.hs, ed.vs, ed.blank});
            popped = sb_def.pop_front();
        end
        check("def_delayed_hs_vs_blank", {vif.hs_d, vif.vs_d, vif.blank_d}, popped);

        es = model(n_s, SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP);
        check("s_DrawX", sif.DrawX, es.x);
        check("s_DrawY", sif.DrawY, es.y);
        check("s_hs", sif.hs, es.hs);
        check("s_vs", sif.vs, es.vs);
        check("s_blank", sif.blank, es.blank);
        check("s_frame_start", sif.frame_start, es.fs);
        check("s_vblank_start", sif.vblank_start, es.vb);
        check("s_passthru_hs_vs_blank", {sif.hs_d, sif.vs_d, sif.blank_d}, {es.hs, es.vs, es.blank});
`ifdef VGA_FRAME_COUNT_EN
        check("def_frame_count", vif.frame_count, ed.fc);
        check("s_frame_count", sif.frame_count, es.fc);
`endif
    end

    typedef struct {
        int   n;
        int   x;
        int   y;
        logic hs, vs, blank, fs, vb;
    } vec_t;
    vec_t tbl[10];

    task automatic wait_def(input int target);
        int k = 0;
        while (n_def != target && k < 5000) begin
            @(negedge vga_clk);
            k++;
        end
        check("wait_def_cycle", n_def, target);
    endtask

    initial begin
        int hs_low, vs_low, vb_cnt, fs_cnt, k;

        tbl[0] = '{1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{2,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{640, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{641, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{656, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{657, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{752, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{753, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{800, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{801, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge vga_clk);
        check("rst_DrawX", vif.DrawX, 0);
        check("rst_hs", vif.hs, 1);
        check("rst_blank_d", vif.blank_d, 0);
        check("rst_frame_start", vif.frame_start, 0);
        rst   = 1'b0;
        rst_s = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wait_def(tbl[i].n);
            check("tbl_DrawX", vif.DrawX, tbl[i].x);
            check("tbl_DrawY", vif.DrawY, tbl[i].y);
            check("tbl_hs", vif.hs, tbl[i].hs);
            check("tbl_vs", vif.vs, tbl[i].vs);
            check("tbl_blank", vif.blank, tbl[i].blank);
            check("tbl_frame_start", vif.frame_start, tbl[i].fs);
            check("tbl_vblank_start", vif.vblank_start, tbl[i].vb);
        end

        // Line 1 of the full-size raster: hsync must be low exactly 96 cycles.
        hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            if (!vif.hs) hs_low++;
            @(negedge vga_clk);
        end
        check("def_hs_low_cycles", hs_low, 96);

        // Reset in the middle of hsync on line 2 (DrawX=700).
        wait_def(2301);
        check("pre_rst_hs_d", vif.hs_d, 0);
        #5 rst = 1'b1;
        #1;
        check("async_DrawX", vif.DrawX, 0);
        check("async_DrawY", vif.DrawY, 0);
        check("async_hs", vif.hs, 1);
        check("async_hs_d", vif.hs_d, 1);
        check("async_blank_d", vif.blank_d, 0);
        repeat (2) @(negedge vga_clk);
        rst = 1'b0;
        @(negedge vga_clk);
        check("restart_DrawX", vif.DrawX, 0);
        check("restart_frame_start", vif.frame_start, 1);
        check("restart_blank", vif.blank, 1);
        @(negedge vga_clk);
        check("restart_DrawX_next", vif.DrawX, 1);
        check("restart_frame_start_next", vif.frame_start, 0);

        // One full reduced frame: vsync width, single vblank strobe, frame period.
        k = 0;
        while (!sif.frame_start && k < 2 * SFT) begin
            @(negedge vga_clk);
            k++;
        end
        check("s_found_frame_start", sif.frame_start, 1);
        vs_low = 0; vb_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < SFT; i++) begin
            if (!sif.vs) vs_low++;
            if (sif.vblank_start) begin
                vb_cnt++;
                check("s_vblank_at_y", sif.DrawY, SV_VIS);
            end
            if (sif.frame_start) fs_cnt++;
            @(negedge vga_clk);
        end
        check("s_vs_low_cycles", vs_low, 2 * SHT);
        check("s_vblank_count", vb_cnt, 1);
        check("s_frame_start_count", fs_cnt, 1);
        check("s_frame_period", sif.frame_start, 1);

        // Reset the reduced instance mid-visible (DrawX=20, DrawY=10).
        k = 0;
        while (!(sif.DrawX == 10'd20 && sif.DrawY == 10'd10) && k < 2 * SFT) begin
            @(negedge vga_clk);
            k++;
        end
        check("s_found_20_10", sif.blank, 1);
        #5 rst_s = 1'b1;
        #1;
        check("s_async_DrawX", sif.DrawX, 0);
        check("s_async_DrawY", sif.DrawY, 0);
        check("s_async_blank", sif.blank, 0);
        check("s_async_blank_d", sif.blank_d, 0);
        @(negedge vga_clk);
        rst_s = 1'b0;
        @(negedge vga_clk);
        check("s_restart_frame_start", sif.frame_start, 1);
        check("s_restart_DrawY", sif.DrawY, 0);

        // Let a few reduced frames elapse under the per-cycle model.
        repeat (3 * SFT + 10) @(negedge vga_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
